// File: rtl/mem_lsu.sv
// Load/store unit: byte/half/word requests to a word-wide MMU port, RMW for sub-word stores.
// Latency: load 2+MEM_RD_LATENCY, word store 2, sub-word store 3+MEM_RD_LATENCY, error 1; one request in flight, req_ready low while busy.
module mem_lsu #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_WIDTH     = 8,
    parameter int MEM_RD_LATENCY = 1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_rw,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_op,
    output logic                  mem_rw,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_w,
    input  logic [DATA_WIDTH-1:0] mem_data_r
);
    localparam int CNT_W = $clog2(MEM_RD_LATENCY) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_RD_LATENCY - 1);
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [2:0] {IDLE, RD, RD_WAIT, RMW_RD, RMW_WAIT, WR, RESP} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            size_q, size_d;
    logic                  signed_q, signed_d;
    logic [1:0]            addr_lo_q, addr_lo_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;
    logic                  mem_op_q, mem_op_d;
    logic                  mem_rw_q, mem_rw_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_w_q, mem_data_w_d;

    logic [DATA_WIDTH-1:0] lane_mask, shifted_rd, ld_val, merged;
    logic                  sign_bit, misaligned;
    int                    sh;

    // Lane extraction for loads and lane merge for RMW stores share one shift amount.
    always_comb begin
        lane_mask  = (size_q == SZ_B) ? DATA_WIDTH'({BYTE_WIDTH{1'b1}})
                                      : DATA_WIDTH'({2*BYTE_WIDTH{1'b1}});
        sh         = (size_q == SZ_B) ? int'(addr_lo_q) * BYTE_WIDTH
                                      : int'(addr_lo_q[1]) * 2 * BYTE_WIDTH;
        shifted_rd = mem_data_r >> sh;
        sign_bit   = (size_q == SZ_B) ? shifted_rd[BYTE_WIDTH-1] : shifted_rd[2*BYTE_WIDTH-1];
        if (size_q == SZ_W) begin
            ld_val = mem_data_r;
        end else begin
            ld_val = (shifted_rd & lane_mask) | ((signed_q && sign_bit) ? ~lane_mask : '0);
        end
        merged     = (mem_data_r & ~(lane_mask << sh)) | ((wdata_q & lane_mask) << sh);
        misaligned = (req_size == 2'b11)
                  || (req_size == SZ_H && req_addr[0])
                  || (req_size == SZ_W && req_addr[1:0] != 2'b00);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        size_d       = size_q;
        signed_d     = signed_q;
        addr_lo_d    = addr_lo_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        mem_op_d     = 1'b0;
        mem_rw_d     = mem_rw_q;
        mem_addr_d   = mem_addr_q;
        mem_data_w_d = mem_data_w_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    size_d    = req_size;
                    signed_d  = req_signed;
                    addr_lo_d = req_addr[1:0];
                    wdata_d   = req_wdata;
                    cnt_d     = '0;
                    if (misaligned) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        mem_op_d   = 1'b1;
                        mem_addr_d = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        if (!req_rw) begin
                            state_d  = RD;
                            mem_rw_d = 1'b0;
                        end else if (req_size == SZ_W) begin
                            state_d      = WR;
                            mem_rw_d     = 1'b1;
                            mem_data_w_d = req_wdata;
                        end else begin
                            state_d  = RMW_RD;
                            mem_rw_d = 1'b0;
                        end
                    end
                end
            end
            RD:     state_d = RD_WAIT;
            RMW_RD: state_d = RMW_WAIT;
            RD_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = ld_val;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RMW_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d      = WR;
                    mem_op_d     = 1'b1;
                    mem_rw_d     = 1'b1;
                    mem_data_w_d = merged;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WR: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            size_q       <= '0;
            signed_q     <= 1'b0;
            addr_lo_q    <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_op_q     <= 1'b0;
            mem_rw_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_w_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            addr_lo_q    <= addr_lo_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_op_q     <= mem_op_d;
            mem_rw_q     <= mem_rw_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_w_q <= mem_data_w_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_op     = mem_op_q;
    assign mem_rw     = mem_rw_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data_w = mem_data_w_q;
endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a response scoreboard and a one-cycle-latency memory model.
module tb_mem_lsu;
    logic        sys_clk;
    logic        sys_rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_rw;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_op;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_w;
    logic [31:0] mem_data_r;

    mem_lsu dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rw     (req_rw),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_op     (mem_op),
        .mem_rw     (mem_rw),
        .mem_addr   (mem_addr),
        .mem_data_w (mem_data_w),
        .mem_data_r (mem_data_r)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          tick     = 0;
    int          acc_tick = 0;
    int          n_acc    = 0;
    int          n_resp   = 0;
    int          log_cyc[4];
    logic        log_rw[4];
    logic [31:0] log_addr[4];
    logic [31:0] log_dat[4];
    logic [31:0] mem[64];

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge sys_clk) begin
        tick <= tick + 1;
        if (mem_op && mem_rw)  mem[mem_addr[7:2]] <= mem_data_w;
        if (mem_op && !mem_rw) mem_data_r <= mem[mem_addr[7:2]];
    end

    // Access log and response scoreboard, sampled mid-cycle.
    always @(negedge sys_clk) begin
        if (mem_op) begin
            if (n_acc < 4) begin
                log_cyc[n_acc[1:0]]  = tick - acc_tick;
                log_rw[n_acc[1:0]]   = mem_rw;
                log_addr[n_acc[1:0]] = mem_addr;
                log_dat[n_acc[1:0]]  = mem_data_w;
            end
            n_acc++;
        end
        if (resp_valid) begin
            exp_t e;
            n_resp++;
            chk1("sb_resp_expected", exp_q.size() > 0, 1'b1);
            chk1("resp_ready_low", req_ready, 1'b0);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk32("sb_rdata", resp_rdata, e.rd);
                chk1("sb_err", resp_err, e.err);
            end
        end
    end

    task automatic xact(input logic rw, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input logic [31:0] exp_wr, input int exp_ops, input int exp_cyc);
        int cyc;
        @(negedge sys_clk);
        chk1("req_ready_idle", req_ready, 1'b1);
        req_valid  = 1'b1;
        req_rw     = rw;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        exp_q.push_back({exp_rd, exp_err});
        n_acc    = 0;
        acc_tick = tick;
        @(posedge sys_clk);
        #1;
        req_valid  = 1'b0;
        req_rw     = ~rw;
        req_size   = ~sz;
        req_signed = ~sg;
        req_addr   = ~a;
        req_wdata  = ~wd;
        cyc = 0;
        do begin
            @(negedge sys_clk);
            cyc++;
        end while (!resp_valid && cyc < 20);
        chk32("resp_cycle", cyc, exp_cyc);
        chk32("mem_access_count", n_acc, exp_ops);
        if (exp_ops > 0 && n_acc > 0) begin
            chk32("acc0_cycle", log_cyc[0], 1);
            chk32("acc0_addr", log_addr[0], a & 32'hFFFF_FFFC);
            chk1("acc0_rw", log_rw[0], rw && exp_ops == 1);
            if (rw && exp_ops == 1) chk32("word_wdata", log_dat[0], exp_wr);
        end
        if (exp_ops == 2 && n_acc > 1) begin
            chk32("acc1_cycle", log_cyc[1], 3);
            chk1("acc1_rw", log_rw[1], 1'b1);
            chk32("acc1_addr", log_addr[1], a & 32'hFFFF_FFFC);
            chk32("rmw_wdata", log_dat[1], exp_wr);
        end
    endtask

    initial begin
        int r0;
        sys_rst    = 1'b1;
        req_valid  = 1'b0;
        req_rw     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;

        repeat (3) @(negedge sys_clk);
        chk1("rst_req_ready", req_ready, 1'b0);
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk1("rst_mem_op", mem_op, 1'b0);
        chk1("rst_mem_rw", mem_rw, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk32("rst_mem_data_w", mem_data_w, 32'h0);
        chk32("rst_resp_rdata", resp_rdata, 32'h0);
        chk1("rst_resp_err", resp_err, 1'b0);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk1("post_rst_ready", req_ready, 1'b1);
        chk1("idle_mem_op", mem_op, 1'b0);
        @(negedge sys_clk);
        chk1("idle_mem_op2", mem_op, 1'b0);

        //   rw    size   sgn   addr    wdata          exp_rd         err   exp_wr         ops cyc
        xact(1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678, 32'h0,          1'b0, 32'h12345678, 1, 2);
        xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h12345678,   1'b0, 32'h0,        1, 3);
        xact(1'b1, 2'b00, 1'b0, 32'h13, 32'h777777AB, 32'h0,          1'b0, 32'hAB345678, 2, 4);
        xact(1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        32'hFFFFFFAB,   1'b0, 32'h0,        1, 3);
        xact(1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        32'h000000AB,   1'b0, 32'h0,        1, 3);
        xact(1'b0, 2'b00, 1'b1, 32'h10, 32'h0,        32'h00000078,   1'b0, 32'h0,        1, 3);
        xact(1'b1, 2'b01, 1'b0, 32'h12, 32'h55558001, 32'h0,          1'b0, 32'h80015678, 2, 4);
        xact(1'b0, 2'b01, 1'b1, 32'h12, 32'h0,        32'hFFFF8001,   1'b0, 32'h0,        1, 3);
        xact(1'b0, 2'b01, 1'b0, 32'h10, 32'h0,        32'h00005678,   1'b0, 32'h0,        1, 3);
        xact(1'b0, 2'b10, 1'b0, 32'h0E, 32'h0,        32'h0,          1'b1, 32'h0,        0, 1);
        xact(1'b0, 2'b01, 1'b0, 32'h11, 32'h0,        32'h0,          1'b1, 32'h0,        0, 1);
        xact(1'b0, 2'b11, 1'b0, 32'h10, 32'h0,        32'h0,          1'b1, 32'h0,        0, 1);

        // Illegal-size store with req_valid held through the RESP edge: one response only.
        @(negedge sys_clk);
        chk1("held_ready", req_ready, 1'b1);
        req_valid = 1'b1;
        req_rw    = 1'b1;
        req_size  = 2'b11;
        req_addr  = 32'h10;
        exp_q.push_back({32'h0, 1'b1});
        n_acc = 0;
        r0    = n_resp;
        @(negedge sys_clk);
        chk1("held_resp_valid", resp_valid, 1'b1);
        @(posedge sys_clk);
        #1;
        req_valid = 1'b0;
        @(negedge sys_clk);
        chk1("held_resp_drop", resp_valid, 1'b0);
        chk1("held_err_drop", resp_err, 1'b0);
        chk1("held_ready_back", req_ready, 1'b1);
        repeat (3) @(negedge sys_clk);
        chk32("held_resp_count", n_resp - r0, 1);
        chk32("held_mem_ops", n_acc, 0);

        // Byte store aborted by reset while waiting on the RMW read.
        @(negedge sys_clk);
        chk1("abort_ready", req_ready, 1'b1);
        req_valid  = 1'b1;
        req_rw     = 1'b1;
        req_size   = 2'b00;
        req_addr   = 32'h11;
        req_wdata  = 32'hCD;
        n_acc      = 0;
        acc_tick   = tick;
        r0         = n_resp;
        @(posedge sys_clk);
        #1;
        req_valid = 1'b0;
        @(negedge sys_clk);
        chk1("abort_rmw_rd_op", mem_op, 1'b1);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        chk1("abort_mem_op", mem_op, 1'b0);
        chk1("abort_ready_rst", req_ready, 1'b0);
        chk32("abort_mem_addr", mem_addr, 32'h0);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk1("abort_ready_after", req_ready, 1'b1);
        repeat (3) @(negedge sys_clk);
        chk32("abort_mem_ops", n_acc, 1);
        chk32("abort_resp_count", n_resp - r0, 0);
        xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h80015678, 1'b0, 32'h0, 1, 3);

        repeat (2) @(negedge sys_clk);
        chk32("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store initiator between the CPU pipeline and the word-wide MMU memory port (op/rw/addr/data_w/data_r); it drives the MMU from the requester side.
- Accepts byte, halfword and word loads/stores from the pipeline. Issues word-aligned MMU accesses and performs read-modify-write for sub-word stores.
- Returns load data sign- or zero-extended. Flags misaligned accesses without touching memory.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, MMU data width; only 32 is supported.
- BYTE_WIDTH, 8, bits per byte lane.
- MEM_RD_LATENCY, 1, cycles from the mem_op read cycle to mem_data_r valid; must be >=1.

Ports:
- sys_clk  in  1  clock; all logic on the rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  LSU can accept a request this cycle.
- req_rw  in  1  0=load, 1=store.
- req_size  in  2  00=byte, 01=half, 10=word, 11=illegal.
- req_signed  in  1  loads only: 1 sign-extends, 0 zero-extends.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data; the value sits in the low bits.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_WIDTH  load result; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal size.
- mem_op  out  1  MMU access strobe.
- mem_rw  out  1  0=read, 1=write.
- mem_addr  out  ADDR_WIDTH  word-aligned address (bits [1:0]=0).
- mem_data_w  out  DATA_WIDTH  write word.
- mem_data_r  in  DATA_WIDTH  read word from the MMU.

Behaviour:
- All outputs are registered. While sys_rst=1, every output is 0 on the next edge and state returns to IDLE.
- States: IDLE, RD, RD_WAIT, RMW_RD, RMW_WAIT, WR, RESP.
- req_ready=1 only in IDLE and not in reset. A request is accepted when req_valid&&req_ready (cycle 0). The LSU latches req fields; changes to req_* after acceptance are ignored.
- Lanes are little-endian: lane k = bits [8k+7:8k].
- Misaligned cases: half with addr[0]=1, word with addr[1:0]!=0, or size=11. These go IDLE->RESP with resp_err=1 and resp_rdata=0 in cycle 1; mem_op is never asserted.
- Load path:
  - Cycle 1: RD, mem_op=1, mem_rw=0, mem_addr={addr[31:2],2'b00}.
  - RD_WAIT counts MEM_RD_LATENCY-1 further cycles. mem_data_r is sampled at the end of cycle 1+MEM_RD_LATENCY.
  - RESP follows in cycle 2+MEM_RD_LATENCY.
  - Extraction: byte takes lane addr[1:0]; half takes lanes {addr[1],1}:{addr[1],0}; word is unmodified. Extension follows req_signed.
- Word store:
  - Cycle 1: WR, mem_op=1, mem_rw=1, mem_data_w=req_wdata.
  - Cycle 2: RESP.
- Sub-word store:
  - Cycle 1: RMW_RD read of the aligned word; the word is sampled as in the load path.
  - Cycle 2+MEM_RD_LATENCY: WR. The selected lane(s) are replaced by req_wdata[7:0] or [15:0]; other lanes keep the read value.
  - Cycle 3+MEM_RD_LATENCY: RESP.
- mem_op is a single-cycle pulse per access and is 0 in all other states. mem_addr, mem_rw and mem_data_w hold their last values when mem_op=0.
- RESP: resp_valid=1 for exactly one cycle, req_ready=0; next state is IDLE. resp_rdata and resp_err return to 0 the following cycle.
- Back-to-back: a new request can be accepted in the cycle after RESP. req_valid during busy states is ignored, with no queuing.
- Reset mid-operation (any state): next cycle IDLE and all outputs 0. A pending RMW write is never issued and no resp_valid is produced for the aborted request.
- The wait counter width is clog2(MEM_RD_LATENCY)+1 and is cleared on every entry to RD or RMW_RD.

Test Plan:
- Hold reset 3 cycles -> all outputs 0. Release -> req_ready=1 the next cycle; mem_op stays 0 with no request.
- Word store 0x12345678 at 0x10 -> cycle 1: mem_op=1, rw=1, addr=0x10, data_w=0x12345678; cycle 2: resp_valid=1, err=0. Word load at 0x10 -> mem read in cycle 1, resp_valid in cycle 3 with rdata=0x12345678 (MEM_RD_LATENCY=1).
- Byte store 0xAB at 0x13 over 0x12345678 -> read 0x10 in cycle 1, write 0xAB345678 in cycle 3, resp in cycle 4. Signed byte load at 0x13 -> 0xFFFFFFAB; unsigned -> 0x000000AB.
- Half store 0x8001 at 0x12, then signed half load at 0x12 -> 0xFFFF8001. Unsigned half load at 0x10 -> 0x00005678.
- Word load at 0x0E, half at 0x11, and size=11 -> each gives resp_valid with resp_err=1 in cycle 1, mem_op never high. req_valid held high during RESP is not accepted twice.
- Sub-word store with sys_rst pulsed in RMW_WAIT -> no write access is issued, no resp_valid, req_ready=1 after reset release; the memory word is unchanged.
